// File: rtl/squeeze_pkg.sv
// Shared constants, FSM state type and the fire-configuration table for the squeeze write-back.
package squeeze_pkg;
    localparam int LANES  = 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int PSUM_W = 24;
    localparam int BIAS_W = 16;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic [5:0] ch_grps;
        logic [5:0] size;
        logic [3:0] f_grps;
    } fire_cfg_t;

    function automatic fire_cfg_t fire_lookup(input logic [2:0] sel);
        fire_cfg_t c;
        case (sel)
            3'd0:    c = '{6'd4,  6'd55, 4'd2};
            3'd1:    c = '{6'd8,  6'd55, 4'd2};
            3'd2:    c = '{6'd8,  6'd27, 4'd4};
            3'd3:    c = '{6'd16, 6'd27, 4'd4};
            3'd4:    c = '{6'd16, 6'd13, 4'd6};
            3'd5:    c = '{6'd24, 6'd13, 4'd6};
            3'd6:    c = '{6'd24, 6'd13, 4'd8};
            default: c = '{6'd32, 6'd13, 4'd8};
        endcase
        return c;
    endfunction
endpackage

// File: rtl/squeeze_ofm_drain.sv
// Hold buffer for one finished pixel (all lanes) and its serialiser onto the output-RAM write port.
module squeeze_ofm_drain
    import squeeze_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       plane,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [LANES*OUT_W-1:0]  load_data,
    input  logic [ADDR_W-1:0]       load_addr,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [OUT_W-1:0]        wr_data
);
    logic                    full;
    logic [LANE_W-1:0]       lane;
    logic [LANES*OUT_W-1:0]  hold_data;
    logic [ADDR_W-1:0]       hold_addr;

    assign load_ready = !full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            full    <= 1'b0;
            lane    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (full) begin
                wr_en   <= 1'b1;
                wr_addr <= hold_addr;
                wr_data <= hold_data[OUT_W-1:0];
                // Buffer frees on the lane-7 issue so a new load is possible the next cycle.
                if (lane == LANE_W'(LANES - 1)) begin
                    full <= 1'b0;
                    lane <= '0;
                end else begin
                    lane <= lane + 1'b1;
                end
            end else if (load_valid) begin
                full <= 1'b1;
            end
        end
    end

    // Lanes shift down one slot per write; each next filter lies one plane further on.
    always_ff @(posedge clk) begin
        if (full) begin
            hold_data <= hold_data >> OUT_W;
            hold_addr <= hold_addr + plane;
        end else if (load_valid) begin
            hold_data <= load_data;
            hold_addr <= load_addr;
        end
    end
endmodule

// File: rtl/squeeze_ofm_writer.sv
// Squeeze 1x1 write-back: accumulates PE partial sums over channel groups, adds bias,
// applies ReLU and saturation, and hands each finished pixel to the lane serialiser.
module squeeze_ofm_writer
    import squeeze_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               firesel,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*PSUM_W-1:0]  in_psum,
    input  logic [LANES*BIAS_W-1:0]  in_bias,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [OUT_W-1:0]         wr_data,
    output state_e                   state_dbg
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);

    state_e                   state;
    fire_cfg_t                cfg;
    fire_cfg_t                new_cfg;
    logic [ADDR_W-1:0]        plane, fgrp_base, pos;
    logic [5:0]               ch_cnt, col, row;
    logic [3:0]               fgrp;
    logic                     done_r;
    logic signed [ACC_W-1:0]  acc [LANES];
    logic signed [ACC_W-1:0]  sum [LANES];
    logic [LANES*OUT_W-1:0]   load_data;
    logic                     load_ready, last_ch, last_pix, xfer, complete;

    // Handshake: a transfer happens on any cycle with in_valid && in_ready; the source keeps
    // lanes and bias stable while in_valid is high and in_ready low. The completing transfer
    // of a pixel is only accepted when the hold buffer can take it (load_valid && load_ready).
    assign new_cfg   = fire_lookup(firesel);
    assign last_ch   = (ch_cnt == cfg.ch_grps - 6'd1);
    assign last_pix  = (col == cfg.size - 6'd1) && (row == cfg.size - 6'd1) &&
                       (fgrp == cfg.f_grps - 4'd1);
    assign in_ready  = (state == RUN) && !(last_ch && !load_ready);
    assign xfer      = in_valid && in_ready;
    assign complete  = xfer && last_ch;
    assign busy      = (state != IDLE);
    assign done      = done_r;
    assign state_dbg = state;

    always_comb begin
        load_data = '0;
        for (int l = 0; l < LANES; l++) begin
            sum[l] = (ch_cnt == '0)
                ? {{(ACC_W-PSUM_W){in_psum[l*PSUM_W+PSUM_W-1]}}, in_psum[l*PSUM_W +: PSUM_W]} +
                  {{(ACC_W-BIAS_W){in_bias[l*BIAS_W+BIAS_W-1]}}, in_bias[l*BIAS_W +: BIAS_W]}
                : acc[l] +
                  {{(ACC_W-PSUM_W){in_psum[l*PSUM_W+PSUM_W-1]}}, in_psum[l*PSUM_W +: PSUM_W]};
            if (sum[l][ACC_W-1])
                load_data[l*OUT_W +: OUT_W] = '0;
            else if (sum[l] > SAT_MAX)
                load_data[l*OUT_W +: OUT_W] = OUT_W'(SAT_MAX);
            else
                load_data[l*OUT_W +: OUT_W] = sum[l][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cfg       <= '0;
            plane     <= '0;
            fgrp_base <= '0;
            pos       <= '0;
            ch_cnt    <= '0;
            col       <= '0;
            row       <= '0;
            fgrp      <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg       <= new_cfg;
                        plane     <= ADDR_W'(new_cfg.size) * ADDR_W'(new_cfg.size);
                        fgrp_base <= '0;
                        pos       <= '0;
                        ch_cnt    <= '0;
                        col       <= '0;
                        row       <= '0;
                        fgrp      <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (xfer && !last_ch) begin
                        ch_cnt <= ch_cnt + 6'd1;
                    end else if (complete) begin
                        ch_cnt <= '0;
                        // pos tracks row*size+col; a row step is also +1 in that space.
                        if (col == cfg.size - 6'd1) begin
                            col <= '0;
                            if (row == cfg.size - 6'd1) begin
                                row       <= '0;
                                pos       <= '0;
                                fgrp      <= fgrp + 4'd1;
                                fgrp_base <= fgrp_base + (plane << LANE_W);
                            end else begin
                                row <= row + 6'd1;
                                pos <= pos + ADDR_W'(1);
                            end
                        end else begin
                            col <= col + 6'd1;
                            pos <= pos + ADDR_W'(1);
                        end
                        if (last_pix)
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (load_ready) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int l = 0; l < LANES; l++)
                acc[l] <= sum[l];
        end
    end

    squeeze_ofm_drain u_drain (
        .clk        (clk),
        .rst        (rst),
        .plane      (plane),
        .load_valid (complete),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_addr  (fgrp_base + pos),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );
endmodule
